// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: ROM read port plus the valid/ready instruction
// handshake toward the decoder.
//   rom_en / rom_addr : fetch -> ROM read request
//   rom_data          : ROM -> fetch, valid the cycle after rom_en
//   instr_out         : held instruction to the decoder
//   out_valid         : instr_out is valid
//   out_ready         : decoder accepts instr_out
// master = fetch stage, slave = ROM + decoder side.
interface instr_fetch_if #(
  parameter int INSTR_BIT = 8
);
  logic                 rom_en;
  logic [INSTR_BIT-1:0] rom_addr;
  logic [31:0]          rom_data;
  logic [31:0]          instr_out;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output rom_en, rom_addr, instr_out, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_en, rom_addr, instr_out, out_valid,
    output rom_data, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the matrix co-processor.
// Owns the PC, reads one 32-bit instruction at a time from a synchronous-read
// ROM and offers it to the decoder through a valid/ready handshake. Only the
// top three opcode bits are predecoded: 110 = jump, 111 = done (halt).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : pulse, begins execution at PC 0 (honoured in IDLE/HALT only)
//   bus      : instr_fetch_if master (ROM port + instruction handshake)
//   pc       : address of the instruction being fetched or held
//   busy     : high in REQ, WAIT and HOLD
//   halted   : high in HALT
//
// state | meaning
// IDLE  | after reset, waiting for start
// REQ   | ROM read issued at pc
// WAIT  | ROM data returning, captured at end of cycle
// HOLD  | instruction presented, waiting for accept
// HALT  | done opcode accepted, waiting for start
module instr_fetch #(
  parameter int INSTR_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  instr_fetch_if.master        bus,
  output logic [INSTR_BIT-1:0] pc,
  output logic                 busy,
  output logic                 halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_JUMP = 3'b110;
  localparam logic [2:0] OP_DONE = 3'b111;

  state_t               state, state_nxt;
  logic [INSTR_BIT-1:0] pc_nxt;
  logic [31:0]          instr_q, instr_nxt;
  logic [2:0]           opcode;
  logic [INSTR_BIT-1:0] jump_tgt;

  assign opcode   = instr_q[31:29];
  // Jump target sits directly below the opcode field.
  assign jump_tgt = instr_q[28 -: INSTR_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_REQ;
        end
      end
      S_REQ: state_nxt = S_WAIT;
      S_WAIT: begin
        // Only load point for instr_q, so data arriving after a reset
        // (which forces IDLE) can never be captured.
        instr_nxt = bus.rom_data;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // out_valid is implied by HOLD, so accept reduces to out_ready here.
        if (bus.out_ready) begin
          case (opcode)
            OP_DONE: state_nxt = S_HALT;
            OP_JUMP: begin
              pc_nxt    = jump_tgt;
              state_nxt = S_REQ;
            end
            default: begin
              pc_nxt    = pc + INSTR_BIT'(1);
              state_nxt = S_REQ;
            end
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  assign bus.rom_en    = (state == S_REQ);
  assign bus.rom_addr  = pc;
  assign bus.instr_out = instr_q;
  assign bus.out_valid = (state == S_HOLD);
  assign busy          = (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);
  assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural model predicts every
// output each cycle, and directed scenarios pin cycle-exact literal values.
module tb_instr_fetch;
  localparam int IB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IB-1:0] pc;
  logic          busy;
  logic          halted;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] rom [0:(1<<IB)-1];
  logic [31:0] rom_data_r;

  instr_fetch_if #(.INSTR_BIT(IB)) bus ();

  instr_fetch #(.INSTR_BIT(IB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .busy   (busy),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM: data appears the cycle after rom_en.
  always @(posedge clk) if (bus.rom_en) rom_data_r <= rom[bus.rom_addr];
  assign bus.rom_data = rom_data_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: "running" with t = cycles since the fetch was issued
  // (0 = request, 1 = data returning, 2 = instruction presented).
  bit          m_init = 0;
  bit          m_run, m_halt;
  int          m_t;
  logic [IB-1:0] m_pc;
  logic [31:0] m_instr;

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1;
      m_run   <= 0;
      m_halt  <= 0;
      m_t     <= 0;
      m_pc    <= '0;
      m_instr <= '0;
    end else if (!m_run && start) begin
      m_run  <= 1;
      m_halt <= 0;
      m_t    <= 0;
      m_pc   <= '0;
    end else if (m_run) begin
      if (m_t < 2) begin
        m_t <= m_t + 1;
        if (m_t == 1) m_instr <= rom[m_pc];
      end else if (bus.out_ready) begin
        if (m_instr[31:29] == 3'd7) begin
          m_run  <= 0;
          m_halt <= 1;
        end else begin
          m_t  <= 0;
          m_pc <= (m_instr[31:29] == 3'd6) ? m_instr[28:21] : m_pc + 8'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("m_rom_en",    32'(bus.rom_en),    32'(m_run && m_t == 0));
      check("m_rom_addr",  32'(bus.rom_addr),  32'(m_pc));
      check("m_out_valid", 32'(bus.out_valid), 32'(m_run && m_t == 2));
      check("m_instr_out", bus.instr_out,      m_instr);
      check("m_pc",        32'(pc),            32'(m_pc));
      check("m_busy",      32'(busy),          32'(m_run));
      check("m_halted",    32'(halted),        32'(m_halt));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Start sampled at edge 0; returns in cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    cyc   = 0;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < (1<<IB); i++) rom[i] = 32'h0;
    step(2);
    rst = 1'b0;
    step(1);
    check("reset_busy",   32'(busy), 32'h0);
    check("reset_pc",     32'(pc), 32'h0);
    check("reset_instr",  bus.instr_out, 32'h0);
    check("reset_valid",  32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b1;
    step(3);
    check("idle_ready_no_pc", 32'(pc), 32'h0);

    // Sequential program
    rom[0] = 32'h0123_4567;
    rom[1] = 32'h2ABC_DEF0;
    rom[2] = 32'hE000_0000;
    pulse_start();
    check("seq_c1_rom_en", 32'(bus.rom_en), 32'h1);
    step(2);
    check("seq_c3_valid", 32'(bus.out_valid), 32'h1);
    check("seq_c3_instr", bus.instr_out, 32'h0123_4567);
    step(1);
    check("seq_c4_valid", 32'(bus.out_valid), 32'h0);
    step(2);
    check("seq_c6_instr", bus.instr_out, 32'h2ABC_DEF0);
    check("seq_c6_pc", 32'(pc), 32'h1);
    step(3);
    check("seq_c9_instr", bus.instr_out, 32'hE000_0000);
    check("seq_c9_pc", 32'(pc), 32'h2);
    step(1);
    check("seq_c10_halted", 32'(halted), 32'h1);
    step(4);

    // Jump (also restart from HALT)
    rom[0] = 32'hC0A0_0000;
    rom[5] = 32'hE000_0000;
    pulse_start();
    check("jmp_c1_addr", 32'(bus.rom_addr), 32'h0);
    check("jmp_c1_rom_en", 32'(bus.rom_en), 32'h1);
    step(3);
    check("jmp_c4_rom_en", 32'(bus.rom_en), 32'h1);
    check("jmp_c4_addr", 32'(bus.rom_addr), 32'h5);
    step(2);
    check("jmp_c6_pc", 32'(pc), 32'h5);
    step(1);
    check("jmp_c7_halted", 32'(halted), 32'h1);

    // Backpressure, start ignored in HOLD
    rom[0] = 32'h1234_5678;
    rom[1] = 32'hE000_0000;
    bus.out_ready = 1'b0;
    pulse_start();
    step(2);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.out_valid), 32'h1);
      check("bp_instr", bus.instr_out, 32'h1234_5678);
      check("bp_pc", 32'(pc), 32'h0);
      check("bp_rom_en", 32'(bus.rom_en), 32'h0);
      if (i == 2) start = 1'b1;
      step(1);
      start = 1'b0;
    end
    bus.out_ready = 1'b1;
    step(1);
    check("bp_advance_pc", 32'(pc), 32'h1);
    check("bp_advance_rom_en", 32'(bus.rom_en), 32'h1);
    step(3);
    check("bp_c17_halted", 32'(halted), 32'h1);

    // Wrap-around through 0xFF
    rom[0]   = 32'hDFE0_0000;
    rom[255] = 32'h2000_0001;
    pulse_start();
    step(3);
    check("wrap_c4_addr", 32'(bus.rom_addr), 32'hFF);
    step(2);
    check("wrap_c6_pc", 32'(pc), 32'hFF);
    check("wrap_c6_instr", bus.instr_out, 32'h2000_0001);
    step(1);
    check("wrap_c7_rom_en", 32'(bus.rom_en), 32'h1);
    check("wrap_c7_addr", 32'(bus.rom_addr), 32'h0);

    // Reset during WAIT, then rst+start together
    step(1);
    rst = 1'b1;
    step(1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_instr", bus.instr_out, 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_rom_en", 32'(bus.rom_en), 32'h0);
    start = 1'b1;
    step(1);
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'h0);
    step(2);
    check("rst_idle_busy", 32'(busy), 32'h0);

    // Refetch after reset from address 0 with fresh data
    rom[0] = 32'hE000_0000;
    pulse_start();
    step(1);
    check("refetch_c2_instr", bus.instr_out, 32'h0);
    step(1);
    check("refetch_c3_instr", bus.instr_out, 32'hE000_0000);
    check("refetch_c3_pc", 32'(pc), 32'h0);
    step(1);
    check("refetch_c4_halted", 32'(halted), 32'h1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
